// File: rtl/predicate_pkg.sv
// -----------------------------------------------------------------------------
// predicate_pkg
// Shared definitions for the square-vs-threshold predicate evaluator and the
// binary-search controller that drives it.
//   DEFAULT_WIDTH : default operand width of the candidate value x
//   LO_INIT       : initial lower search bound used by the search controller
//   HI_INIT       : initial upper search bound used by the search controller
//   state_t       : evaluator FSM state encoding (IDLE, MUL, DONE)
// -----------------------------------------------------------------------------
package predicate_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [31:0] LO_INIT = 32'h0000_0000;
  localparam logic [31:0] HI_INIT = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : predicate_pkg

// File: rtl/predicate_eval.sv
// -----------------------------------------------------------------------------
// predicate_eval
// Evaluates f(x) = (x*x >= threshold) for the upstream binary search. The
// square is formed by a shift-add multiplier that retires one multiplier bit
// per cycle, so every request takes exactly WIDTH cycles to answer.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   req_valid  : request present
//   req_ready  : block can accept a request (state == IDLE)
//   x          : candidate value, sampled on the request handshake
//   threshold  : comparison bound, sampled on the request handshake
//   rsp_valid  : verdict and product valid (state == DONE)
//   rsp_ready  : consumer accepts the response
//   v          : verdict, 1 when x*x >= threshold (unsigned)
//   prod       : x*x, kept for debug and scoreboarding
// -----------------------------------------------------------------------------
module predicate_eval
  import predicate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [2*WIDTH-1:0]   threshold,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 v,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   thr_q, thr_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            v_q, v_d;

  // Accumulator value after the current multiply step; on the last step this
  // is the finished square, so the verdict is taken from it directly rather
  // than waiting an extra cycle for acc_q.
  logic [PW-1:0]   acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    thr_d    = thr_q;
    prod_d   = prod_q;
    v_d      = v_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = MUL;
          thr_d    = threshold;
          mcand_d  = PW'(x);
          mplier_d = x;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end

      MUL: begin
        // Fixed latency: all WIDTH bits are walked even once mplier is zero.
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          prod_d  = acc_next;
          v_d     = (acc_next >= thr_q);
        end
      end

      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset clears the whole datapath, not just the FSM, so prod and v
      // read as zero afterwards and no stale result leaks out of an aborted
      // request.
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      thr_q    <= '0;
      prod_q   <= '0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      prod_q   <= prod_d;
      v_q      <= v_d;
    end
  end

  // Handshake outputs decode the state register only; no input reaches an
  // output combinationally.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign v         = v_q;
  assign prod      = prod_q;

endmodule : predicate_eval
